mcu_mem_arbiter: RTL and testbench

// Shares the vector core's single memory port between the M_CU load engine and store engine.

---
 rtl/mcu_mem_arbiter_pkg.sv | 20 ++
 rtl/mcu_mem_arbiter_rr_arb2.sv | 28 ++
 rtl/mcu_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mcu_mem_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_mem_arbiter_pkg.sv
// Shared types for the M_CU memory-port arbiter: FSM state encoding and requester ids.
// Optional build macro MCU_ARB_LD_PRIO_EN is consumed by mcu_mem_arbiter.
package mcu_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_LD_ADDR = 3'd1,
    ARB_LD_DATA = 3'd2,
    ARB_ST_ADDR = 3'd3,
    ARB_ST_DATA = 3'd4
  } mcu_arb_state_t;

  localparam logic ARB_LD = 1'b0;
  localparam logic ARB_ST = 1'b1;

  function automatic mcu_arb_state_t arb_addr_state(input logic side);
    return (side == ARB_LD) ? ARB_LD_ADDR : ARB_ST_ADDR;
  endfunction

endpackage

// File: rtl/mcu_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick between load and store requesters, with a load-priority override.
module mcu_mem_arbiter_rr_arb2
  import mcu_mem_arbiter_pkg::*;
(
  input  logic req_ld_i,
  input  logic req_st_i,
  input  logic rr_last_i,
  input  logic prio_ld_i,
  output logic gnt_vld_o,
  output logic gnt_side_o
);

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    gnt_vld_o  = req_ld_i | req_st_i;
    gnt_side_o = ARB_LD;
    if (req_ld_i && req_st_i) begin
      if (prio_ld_i) begin
        gnt_side_o = ARB_LD;
      end else begin
        gnt_side_o = (rr_last_i == ARB_ST) ? ARB_LD : ARB_ST;
      end
    end else if (req_st_i) begin
      gnt_side_o = ARB_ST;
    end
  end

endmodule

// File: rtl/mcu_mem_arbiter.sv
// Burst-granular arbiter sharing one memory port between the M_CU load and store engines.
// Define MCU_ARB_LD_PRIO_EN for fixed load priority; otherwise ties alternate round-robin.
module mcu_mem_arbiter
  import mcu_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_req_vld_i,
  output logic                  ld_req_rdy_o,
  input  logic [ADDR_WIDTH-1:0] ld_req_addr_i,
  input  logic [LEN_WIDTH-1:0]  ld_req_len_i,
  output logic [DATA_WIDTH-1:0] ld_rdata_o,
  output logic                  ld_rdata_vld_o,
  output logic                  ld_rdata_last_o,
  input  logic                  st_req_vld_i,
  output logic                  st_req_rdy_o,
  input  logic [ADDR_WIDTH-1:0] st_req_addr_i,
  input  logic [LEN_WIDTH-1:0]  st_req_len_i,
  input  logic [DATA_WIDTH-1:0] st_wdata_i,
  input  logic                  st_wdata_vld_i,
  output logic                  st_wdata_rdy_o,
  output logic                  mem_req_vld_o,
  input  logic                  mem_req_rdy_i,
  output logic                  mem_req_we_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic [LEN_WIDTH-1:0]  mem_req_len_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_wdata_vld_o,
  input  logic                  mem_wdata_rdy_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_rdata_vld_i
);

  mcu_arb_state_t        state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  rr_last_q, rr_last_d;

  logic prio_ld;
  logic gnt_vld;
  logic gnt_side;
  logic in_idle;
  logic ld_data_act;
  logic st_data_act;
  logic st_beat;

`ifdef MCU_ARB_LD_PRIO_EN
  assign prio_ld = 1'b1;
`else
  assign prio_ld = 1'b0;
`endif

  mcu_mem_arbiter_rr_arb2 u_rr_arb2 (
    .req_ld_i   (ld_req_vld_i),
    .req_st_i   (st_req_vld_i),
    .rr_last_i  (rr_last_q),
    .prio_ld_i  (prio_ld),
    .gnt_vld_o  (gnt_vld),
    .gnt_side_o (gnt_side)
  );

  // Handshake outputs are held low while rst is high, even before the reset edge lands.
  assign in_idle     = !rst && (state_q == ARB_IDLE);
  assign ld_data_act = !rst && (state_q == ARB_LD_DATA);
  assign st_data_act = !rst && (state_q == ARB_ST_DATA);

  assign ld_req_rdy_o = in_idle && gnt_vld && (gnt_side == ARB_LD);
  assign st_req_rdy_o = in_idle && gnt_vld && (gnt_side == ARB_ST);

  assign mem_req_vld_o  = !rst && ((state_q == ARB_LD_ADDR) || (state_q == ARB_ST_ADDR));
  assign mem_req_we_o   = we_q;
  assign mem_req_addr_o = addr_q;
  assign mem_req_len_o  = len_q;

  assign ld_rdata_vld_o  = ld_data_act && mem_rdata_vld_i;
  assign ld_rdata_o      = ld_data_act ? mem_rdata_i : '0;
  assign ld_rdata_last_o = ld_rdata_vld_o && (cnt_q == '0);

  assign mem_wdata_vld_o = st_data_act && st_wdata_vld_i;
  assign mem_wdata_o     = st_data_act ? st_wdata_i : '0;
  assign st_wdata_rdy_o  = st_data_act && mem_wdata_rdy_i;
  assign st_beat         = mem_wdata_vld_o && mem_wdata_rdy_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    addr_d    = addr_q;
    we_d      = we_q;
    rr_last_d = rr_last_q;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_vld) begin
          state_d = arb_addr_state(gnt_side);
          we_d    = (gnt_side == ARB_ST);
          addr_d  = (gnt_side == ARB_LD) ? ld_req_addr_i : st_req_addr_i;
          len_d   = (gnt_side == ARB_LD) ? ld_req_len_i  : st_req_len_i;
        end
      end
      ARB_LD_ADDR, ARB_ST_ADDR: begin
        if (mem_req_rdy_i) begin
          cnt_d   = len_q;
          state_d = (state_q == ARB_LD_ADDR) ? ARB_LD_DATA : ARB_ST_DATA;
        end
      end
      ARB_LD_DATA: begin
        if (mem_rdata_vld_i) begin
          if (cnt_q == '0) begin
            state_d   = ARB_IDLE;
            rr_last_d = ARB_LD;
          end else begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
          end
        end
      end
      ARB_ST_DATA: begin
        if (st_beat) begin
          if (cnt_q == '0) begin
            state_d   = ARB_IDLE;
            rr_last_d = ARB_ST;
          end else begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      rr_last_q <= ARB_ST;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Read beats have no backpressure, so one arriving outside a load burst is lost.
  rdata_only_in_ld_data_a : assert property (@(posedge clk) disable iff (rst)
    mem_rdata_vld_i |-> (state_q == ARB_LD_DATA));

endmodule

// File: tb/tb_mcu_mem_arbiter.sv
// Randomized scoreboard bench for mcu_mem_arbiter: engine and memory models plus an output monitor.
// Build with MCU_ARB_LD_PRIO_EN defined to check the fixed load-priority variant.
module tb_mcu_mem_arbiter;
  import mcu_mem_arbiter_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  len;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        ld_req_vld_i, ld_req_rdy_o;
  logic [31:0] ld_req_addr_i;
  logic [7:0]  ld_req_len_i;
  logic [31:0] ld_rdata_o;
  logic        ld_rdata_vld_o, ld_rdata_last_o;
  logic        st_req_vld_i, st_req_rdy_o;
  logic [31:0] st_req_addr_i;
  logic [7:0]  st_req_len_i;
  logic [31:0] st_wdata_i;
  logic        st_wdata_vld_i, st_wdata_rdy_o;
  logic        mem_req_vld_o, mem_req_rdy_i, mem_req_we_o;
  logic [31:0] mem_req_addr_o;
  logic [7:0]  mem_req_len_o;
  logic [31:0] mem_wdata_o;
  logic        mem_wdata_vld_o, mem_wdata_rdy_i;
  logic [31:0] mem_rdata_i;
  logic        mem_rdata_vld_i;

  mcu_mem_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .ld_req_vld_i    (ld_req_vld_i),
    .ld_req_rdy_o    (ld_req_rdy_o),
    .ld_req_addr_i   (ld_req_addr_i),
    .ld_req_len_i    (ld_req_len_i),
    .ld_rdata_o      (ld_rdata_o),
    .ld_rdata_vld_o  (ld_rdata_vld_o),
    .ld_rdata_last_o (ld_rdata_last_o),
    .st_req_vld_i    (st_req_vld_i),
    .st_req_rdy_o    (st_req_rdy_o),
    .st_req_addr_i   (st_req_addr_i),
    .st_req_len_i    (st_req_len_i),
    .st_wdata_i      (st_wdata_i),
    .st_wdata_vld_i  (st_wdata_vld_i),
    .st_wdata_rdy_o  (st_wdata_rdy_o),
    .mem_req_vld_o   (mem_req_vld_o),
    .mem_req_rdy_i   (mem_req_rdy_i),
    .mem_req_we_o    (mem_req_we_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_len_o   (mem_req_len_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_wdata_vld_o (mem_wdata_vld_o),
    .mem_wdata_rdy_i (mem_wdata_rdy_i),
    .mem_rdata_i     (mem_rdata_i),
    .mem_rdata_vld_i (mem_rdata_vld_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int busy = 0;
  int rd_seen = 0;
  bit abort = 1'b0;
  logic model_last = ARB_ST;

  req_t        exp_req_q[$];
  beat_t       exp_rd_q[$];
  beat_t       exp_wr_q[$];
  req_t        ld_cmd_q[$];
  req_t        st_cmd_q[$];
  logic [31:0] st_beat_q[$];

  bit          mem_rd_active = 1'b0;
  bit          mem_wr_active = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT produced an output with nothing expected (t=%0t)", name, $time);
  endtask

  // Memory contents seen by reads: a fixed scramble of address and beat index.
  function automatic logic [31:0] rd_word(input logic [31:0] a, input int i);
    return a ^ (32'(i) * 32'h9E37_79B9) ^ 32'hC0DE_0000;
  endfunction

  // ---------------- reference model: grant order and expected beats ----------------
  task automatic push_ld(input logic [31:0] a, input logic [7:0] l);
    req_t r;
    r.we = 1'b0; r.addr = a; r.len = l;
    exp_req_q.push_back(r);
    ld_cmd_q.push_back(r);
    for (int i = 0; i <= int'(l); i++) begin
      beat_t b;
      b.data = rd_word(a, i);
      b.last = (i == int'(l));
      exp_rd_q.push_back(b);
    end
  endtask

  task automatic push_st(input logic [31:0] a, input logic [7:0] l);
    req_t r;
    r.we = 1'b1; r.addr = a; r.len = l;
    exp_req_q.push_back(r);
    st_cmd_q.push_back(r);
    for (int i = 0; i <= int'(l); i++) begin
      beat_t b;
      b.data = $urandom;
      b.last = (i == int'(l));
      exp_wr_q.push_back(b);
      st_beat_q.push_back(b.data);
    end
  endtask

  // Issues one round; when both sides request in the same cycle the model decides who goes first.
  task automatic issue(input bit do_ld, input logic [31:0] la, input logic [7:0] ll,
                       input bit do_st, input logic [31:0] sa, input logic [7:0] sl);
    bit ld_first;
    if (do_ld && do_st) begin
`ifdef MCU_ARB_LD_PRIO_EN
      ld_first = 1'b1;
`else
      ld_first = (model_last == ARB_ST);
`endif
      if (ld_first) begin
        push_ld(la, ll); push_st(sa, sl); model_last = ARB_ST;
      end else begin
        push_st(sa, sl); push_ld(la, ll); model_last = ARB_LD;
      end
    end else if (do_ld) begin
      push_ld(la, ll); model_last = ARB_LD;
    end else if (do_st) begin
      push_st(sa, sl); model_last = ARB_ST;
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk); #1;
      done = (exp_req_q.size() == 0) && (exp_rd_q.size() == 0) && (exp_wr_q.size() == 0) &&
             (ld_cmd_q.size() == 0) && (st_cmd_q.size() == 0) && (st_beat_q.size() == 0) &&
             !mem_rd_active && !mem_wr_active && (busy == 0);
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL round_timeout: outstanding req=%0d rd=%0d wr=%0d", exp_req_q.size(),
               exp_rd_q.size(), exp_wr_q.size());
    end
    @(negedge clk);
  endtask

  // ---------------- load engine ----------------
  initial begin : ld_engine
    bit fire;
    ld_req_vld_i = 1'b0; ld_req_addr_i = '0; ld_req_len_i = '0;
    forever begin
      @(negedge clk);
      fire = ld_req_vld_i && ld_req_rdy_o;
      @(posedge clk); #1;
      if (fire) begin
        ld_req_vld_i = 1'b0;
        void'(ld_cmd_q.pop_front());
      end
      if (!ld_req_vld_i && ld_cmd_q.size() > 0) begin
        ld_req_vld_i  = 1'b1;
        ld_req_addr_i = ld_cmd_q[0].addr;
        ld_req_len_i  = ld_cmd_q[0].len;
      end
    end
  end

  // ---------------- store engine ----------------
  initial begin : st_engine
    bit fire, wfire;
    st_req_vld_i = 1'b0; st_req_addr_i = '0; st_req_len_i = '0;
    st_wdata_vld_i = 1'b0; st_wdata_i = '0;
    forever begin
      @(negedge clk);
      fire  = st_req_vld_i && st_req_rdy_o;
      wfire = st_wdata_vld_i && st_wdata_rdy_o;
      @(posedge clk); #1;
      if (fire) begin
        st_req_vld_i = 1'b0;
        void'(st_cmd_q.pop_front());
      end
      if (!st_req_vld_i && st_cmd_q.size() > 0) begin
        st_req_vld_i  = 1'b1;
        st_req_addr_i = st_cmd_q[0].addr;
        st_req_len_i  = st_cmd_q[0].len;
      end
      if (wfire) void'(st_beat_q.pop_front());
      if (st_beat_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        st_wdata_vld_i = 1'b1;
        st_wdata_i     = st_beat_q[0];
      end else begin
        st_wdata_vld_i = 1'b0;
      end
    end
  end

  // ---------------- memory / AXI adapter model ----------------
  initial begin : memory
    bit          fire_req, fire_w, cap_we;
    logic [31:0] cap_addr, rd_addr;
    logic [7:0]  cap_len;
    int          rd_idx, rd_len, wr_left, wr_hold;
    mem_req_rdy_i = 1'b0; mem_wdata_rdy_i = 1'b0; mem_rdata_vld_i = 1'b0; mem_rdata_i = '0;
    rd_idx = 0; rd_len = 0; wr_left = 0; wr_hold = 0; rd_addr = '0;
    forever begin
      @(negedge clk);
      fire_req = mem_req_vld_o && mem_req_rdy_i;
      fire_w   = mem_wdata_vld_o && mem_wdata_rdy_i;
      cap_we   = mem_req_we_o;
      cap_addr = mem_req_addr_o;
      cap_len  = mem_req_len_o;
      @(posedge clk); #1;
      if (abort) begin
        mem_rd_active = 1'b0; mem_wr_active = 1'b0;
        mem_req_rdy_i = 1'b0; mem_wdata_rdy_i = 1'b0; mem_rdata_vld_i = 1'b0;
      end else begin
        if (fire_req) begin
          mem_req_rdy_i = 1'b0;
          if (cap_we) begin
            mem_wr_active = 1'b1; wr_left = int'(cap_len) + 1; wr_hold = 2;
          end else begin
            mem_rd_active = 1'b1; rd_idx = 0; rd_len = int'(cap_len); rd_addr = cap_addr;
          end
        end else if (!mem_rd_active && !mem_wr_active) begin
          mem_req_rdy_i = mem_req_vld_o && ($urandom_range(0, 2) != 0);
        end
        if (mem_rd_active) begin
          if (rd_idx <= rd_len) begin
            if ($urandom_range(0, 3) != 0) begin
              mem_rdata_vld_i = 1'b1;
              mem_rdata_i     = rd_word(rd_addr, rd_idx);
              rd_idx++;
            end else begin
              mem_rdata_vld_i = 1'b0;
            end
          end else begin
            mem_rdata_vld_i = 1'b0;
            mem_rd_active   = 1'b0;
          end
        end
        if (mem_wr_active) begin
          if (fire_w) wr_left--;
          if (wr_left == 0) begin
            mem_wr_active = 1'b0; mem_wdata_rdy_i = 1'b0;
          end else if (wr_hold > 0) begin
            wr_hold--; mem_wdata_rdy_i = 1'b0;
          end else begin
            mem_wdata_rdy_i = ($urandom_range(0, 3) != 0);
          end
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    req_t  er;
    beat_t eb;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_handshakes_low",
              {ld_req_rdy_o, st_req_rdy_o, ld_rdata_vld_o, ld_rdata_last_o,
               st_wdata_rdy_o, mem_req_vld_o, mem_wdata_vld_o}, 64'd0);
      end else begin
        if (ld_req_rdy_o || st_req_rdy_o) begin
          check("accept_only_when_no_burst", 64'(busy), 64'd0);
          check("one_accept_at_a_time", {63'd0, ld_req_rdy_o && st_req_rdy_o}, 64'd0);
          busy++;
        end
        if (mem_req_vld_o && mem_req_rdy_i) begin
          if (exp_req_q.size() == 0) fail_event("mem_req_unexpected");
          else begin
            er = exp_req_q.pop_front();
            check("mem_req_we_addr_len", {mem_req_we_o, mem_req_addr_o, mem_req_len_o},
                  {er.we, er.addr, er.len});
          end
        end
        if (ld_rdata_vld_o) begin
          rd_seen++;
          if (exp_rd_q.size() == 0) fail_event("ld_rdata_unexpected");
          else begin
            eb = exp_rd_q.pop_front();
            check("ld_rdata_data_last", {ld_rdata_o, ld_rdata_last_o}, {eb.data, eb.last});
            if (eb.last) busy--;
          end
        end
        if (mem_wdata_vld_o && mem_wdata_rdy_i) begin
          if (exp_wr_q.size() == 0) fail_event("mem_wdata_unexpected");
          else begin
            eb = exp_wr_q.pop_front();
            check("mem_wdata", {32'd0, mem_wdata_o}, {32'd0, eb.data});
            if (eb.last) busy--;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int base;
    bit got;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_fields_zero",
          {mem_req_we_o, mem_req_addr_o, mem_req_len_o, mem_wdata_o != 32'd0, ld_rdata_o != 32'd0},
          64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);

    issue(1'b1, 32'h0000_0100, 8'd3, 1'b0, '0, '0);
    wait_idle(500);
    issue(1'b0, '0, '0, 1'b1, 32'h0000_0200, 8'd1);
    wait_idle(500);

    // Both requesters together, repeatedly: round-robin alternates, load-priority keeps loads first.
    for (int p = 0; p < 4; p++) begin
      issue(1'b1, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 5)),
            1'b1, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 5)));
      wait_idle(800);
    end

    // Store arrives while a long load burst is in flight.
    issue(1'b1, 32'h0000_0400, 8'd7, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    issue(1'b0, '0, '0, 1'b1, 32'h0000_0500, 8'd2);
    wait_idle(800);

    issue(1'b1, 32'h0000_0600, 8'd0, 1'b1, 32'h0000_0700, 8'd0);
    wait_idle(500);
    issue(1'b1, 32'h0001_0000, 8'd255, 1'b1, 32'h0002_0000, 8'd255);
    wait_idle(3000);

    for (int r = 0; r < 30; r++) begin
      int mode;
      logic [7:0] ll, sl;
      mode = $urandom_range(0, 2);
      ll = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 9));
      sl = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 9));
      issue(mode != 1, $urandom & 32'hFFFF_FFFC, ll, mode != 0, $urandom & 32'hFFFF_FFFC, sl);
      wait_idle(1000);
    end

    // Reset in the middle of a four-beat read, after its second beat.
    base = rd_seen;
    issue(1'b1, 32'h0000_0800, 8'd3, 1'b0, '0, '0);
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk); #1;
      got = (rd_seen >= base + 2);
    end
    check("reset_test_saw_two_beats", {63'd0, got}, 64'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    abort = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    abort = 1'b0;
    exp_rd_q.delete();
    exp_req_q.delete();
    busy = 0;
    model_last = ARB_ST;
    @(negedge clk); #1;
    check("after_midburst_reset_idle",
          {ld_req_rdy_o, st_req_rdy_o, ld_rdata_vld_o, ld_rdata_last_o,
           st_wdata_rdy_o, mem_req_vld_o, mem_wdata_vld_o}, 64'd0);
    issue(1'b1, 32'h0000_0900, 8'd2, 1'b0, '0, '0);
    wait_idle(500);
    issue(1'b1, 32'h0000_0A00, 8'd1, 1'b1, 32'h0000_0B00, 8'd1);
    wait_idle(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
